mcoi_status_framer: RTL and testbench
=====================================

# mcoi_status_framer

Uplink transmitter for the MCOI GBT link. It snapshots the status words of all stepper motors and a diagnostics word once per superframe. It serialises them into a sequence of 80-bit GBT payload frames, each with a marker, an index and a CRC-8. It sits between the motor application and the GBT TX data port in the 40 MHz frame clock domain. It is the counterpart of the downlink command decoder on the receive side.

## Interface

Parameters:
- NUM_MOTORS, 16, number of motor status words; must be a multiple of 4 and no more than 60.

Ports:
- ClkRs_ix  input  ckrs_t  clock/reset bundle:
  - .clk is the 40 MHz GBT frame clock.
  - .reset is synchronous, active-high.
  - The block has one clock; reset is synchronous and active-high.
- enable_i  input  1  transmit enable; sampled only at superframe boundaries.
- frame_strobe_i  input  1  one-cycle pulse: GBT TX consumed the current frame, present the next one.
- motor_status_ib  input  [NUM_MOTORS-1:0][15:0]  per-motor status words.
- diag_ib  input  32  diagnostics word.
- frame_ob  output  80  current TX frame (registered).
- sof_o  output  1  high while frame_ob holds a header frame.
- snapshot_o  output  1  one-cycle pulse in the cycle the new header appears on frame_ob.

## Operation

Frame layout:
- [79:76] marker: 0x0 idle, 0xA header, 0x5 motor.
- [75:72] index.
- [71:8] payload.
- [7:0] CRC-8 over [79:8]:
  - polynomial 0x07;
  - init 0x00;
  - MSB first;
  - no reflection;
  - no final XOR.

Frame contents:
- **Idle frame:** all 80 bits zero. The CRC of zeros is 0x00.
- **Header frame:** index 0.
  - Payload [71:56] is the superframe counter.
  - Payload [55:24] is the snapshotted diag_ib.
  - Payload [23:16] is NUM_MOTORS.
  - Payload [15:8] is 0x00.
- **Motor frame k:** k runs 1..NUM_MOTORS/4 and is carried in the index field. The payload holds snapshotted motors 4(k-1)+3 .. 4(k-1), mapped to [71:56] .. [23:8] in that order.

State machine (advances only on frame_strobe_i):
- **IDLE:** frame_ob carries the idle frame.
  - On strobe with enable_i=1: go to HEADER, snapshot motor_status_ib and diag_ib.
  - On strobe with enable_i=0: stay in IDLE.
- **HEADER:** on strobe, go to MOTOR with k=1.
- **MOTOR(k):**
  - On strobe with k < NUM_MOTORS/4: go to MOTOR(k+1).
  - On strobe with k = last: if enable_i=1, go to HEADER with a new snapshot; otherwise go to IDLE.
- enable_i deasserted mid-superframe has no effect until the superframe completes.

Superframe counter:
- 16 bits, reset to 0.
- The header carries the current value; the counter increments after the header is emitted.
- Wraps from 0xFFFF to 0x0000.

Snapshot:
- Input values are sampled in the strobe cycle that enters HEADER.
- Input changes during a superframe are not visible until the next superframe.

## Timing

- Reset values: frame_ob = 80'h0, sof_o = 0, snapshot_o = 0, state IDLE, counter 0, snapshot registers 0.
- Latency: a strobe in cycle n makes the new frame_ob valid in cycle n+1. frame_ob holds until the next strobe.
- sof_o and snapshot_o are registered and aligned with frame_ob.
- A strobe every cycle is legal; every strobe advances exactly one frame.
- Reset wins over a simultaneous strobe. Reset mid-superframe yields the idle frame in the next cycle, and the next header carries counter 0.
- The CRC is computed combinationally from next-frame fields and registered together with the frame. There is no extra latency.

## Structure

- MCPkg additions:
  - gbt_frame_t (logic [79:0]);
  - marker constants MARK_IDLE, MARK_HEADER, MARK_MOTOR;
  - motor_status_t (logic [15:0]);
  - the framer state enum.
- Sub-module crc8_d72: purely combinational 72-bit-in, 8-bit-out CRC-8 (poly 0x07). It is reused by the downlink decoder.

## Test plan

- **Reset:** assert reset for 3 cycles with random strobes -> frame_ob = 0, sof_o = 0, snapshot_o never pulses.
- **First header:** enable_i=1, diag_ib=32'hDEADBEEF, single strobe -> next cycle:
  - frame_ob[79:72] = 0xA0, counter field 0x0000, diag field 0xDEADBEEF, [23:16] = 0x10;
  - sof_o = 1, snapshot_o = 1;
  - CRC matches the model.
- **Motor frames and snapshot coherency:** motor_status_ib[i] = 16'h1000+i, then 4 strobes -> indices 1..4 with frame 1 payload 0x1003_1002_1001_1000. Changing inputs after the header -> frames unchanged.
- **Enable drop mid-superframe:** deassert enable_i after motor frame 2 -> frames 3 and 4 still sent, then idle frame, next header only after re-enable.
- **Counter wrap:** run 65536 superframes back-to-back with strobe every cycle -> header counter sequence ...0xFFFF, 0x0000.
- **Reset mid-superframe:** reset during motor frame 2 -> idle next cycle. After release and a strobe, the header counter is 0x0000.

Source files
------------

// File: rtl/mcoi_status_framer_pkg.sv
// mcoi_status_framer_pkg
//   Shared types and constants for the MCOI uplink status framer and the
//   downlink decoder: clock/reset bundle, GBT frame type, frame markers,
//   motor status word type and the framer state encoding.
package mcoi_status_framer_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef logic [79:0] gbt_frame_t;
  typedef logic [15:0] motor_status_t;

  localparam logic [3:0] MARK_IDLE   = 4'h0;
  localparam logic [3:0] MARK_HEADER = 4'hA;
  localparam logic [3:0] MARK_MOTOR  = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_MOTOR
  } framer_state_t;

endpackage

// File: rtl/mcoi_status_framer_crc8.sv
// crc8_d72
//   Purely combinational CRC-8 over a 72-bit word: polynomial 0x07,
//   init 0x00, MSB first, no reflection, no final XOR.
//   Ports:
//     data_i [71:0] : data word, bit 71 shifted in first
//     crc_o  [7:0]  : resulting CRC
module crc8_d72 (
  input  logic [71:0] data_i,
  output logic [7:0]  crc_o
);

  always_comb begin
    logic [7:0] w_c;
    logic       w_fb;
    w_c  = 8'h00;
    w_fb = 1'b0;
    for (int i = 71; i >= 0; i--) begin
      w_fb = w_c[7] ^ data_i[i];
      w_c  = {w_c[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
    end
    crc_o = w_c;
  end

endmodule

// File: rtl/mcoi_status_framer.sv
// mcoi_status_framer
//   GBT uplink framer. Once per superframe it snapshots all motor status
//   words and a diagnostics word, then emits a header frame followed by
//   NUM_MOTORS/4 motor frames, one frame per frame_strobe_i. Each frame
//   carries a marker, an index, a 64-bit payload and a CRC-8 over [79:8].
//   Ports:
//     ClkRs_ix        : clock / synchronous active-high reset bundle
//     enable_i        : transmit enable, looked at only at superframe bounds
//     frame_strobe_i  : TX consumed the current frame, present the next
//     motor_status_ib : per-motor status words
//     diag_ib         : diagnostics word
//     frame_ob        : registered 80-bit TX frame
//     sof_o           : frame_ob holds a header frame
//     snapshot_o      : one-cycle pulse when a new header appears
module mcoi_status_framer
  import mcoi_status_framer_pkg::*;
#(
  parameter int NUM_MOTORS = 16
) (
  input  ckrs_t                           ClkRs_ix,
  input  logic                            enable_i,
  input  logic                            frame_strobe_i,
  input  motor_status_t [NUM_MOTORS-1:0]  motor_status_ib,
  input  logic [31:0]                     diag_ib,
  output gbt_frame_t                      frame_ob,
  output logic                            sof_o,
  output logic                            snapshot_o
);

  localparam int         NGRP   = NUM_MOTORS / 4;
  localparam int         GW     = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [3:0] LAST_K = 4'(NGRP);

  framer_state_t                  r_state;
  framer_state_t                  w_next_state;
  logic [3:0]                     r_k;
  logic [3:0]                     w_next_k;
  logic                           w_snap;
  logic                           w_cnt_inc;
  logic [15:0]                    r_sf_cnt;
  motor_status_t [NUM_MOTORS-1:0] r_motor;
  logic [63:0]                    w_grp [NGRP];
  logic [GW-1:0]                  w_gidx;
  logic [71:0]                    w_body;
  logic [7:0]                     w_crc;

  // State register
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      r_state <= ST_IDLE;
      r_k     <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_k     <= w_next_k;
    end
  end

  // Next state: only a strobe moves the machine
  always_comb begin
    w_next_state = r_state;
    w_next_k     = r_k;
    w_snap       = 1'b0;
    w_cnt_inc    = 1'b0;
    if (frame_strobe_i) begin
      unique case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            w_next_state = ST_HEADER;
            w_snap       = 1'b1;
          end
        end
        ST_HEADER: begin
          w_next_state = ST_MOTOR;
          w_next_k     = 4'd1;
          // Header already shows the current count; bump it on the way out.
          w_cnt_inc    = 1'b1;
        end
        ST_MOTOR: begin
          if (r_k < LAST_K) begin
            w_next_k = r_k + 4'd1;
          end else if (enable_i) begin
            w_next_state = ST_HEADER;
            w_snap       = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
            w_next_k     = 4'd0;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_k     = 4'd0;
        end
      endcase
    end
  end

  // Each group of four snapshotted motors, highest motor in the top word
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign w_grp[g] = r_motor[4*g +: 4];
  end

  assign w_gidx = GW'(w_next_k - 4'd1);

  // Next-frame fields. The header is only ever entered together with a
  // snapshot, so it takes diag_ib straight from the port.
  always_comb begin
    w_body = 72'h0;
    unique case (w_next_state)
      ST_HEADER: w_body = {MARK_HEADER, 4'h0, r_sf_cnt, diag_ib,
                           8'(NUM_MOTORS), 8'h00};
      ST_MOTOR:  w_body = {MARK_MOTOR, w_next_k, w_grp[w_gidx]};
      default:   w_body = {MARK_IDLE, 68'h0};
    endcase
  end

  crc8_d72 u_crc (
    .data_i (w_body),
    .crc_o  (w_crc)
  );

  // Output frame, counter and snapshot registers
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      r_sf_cnt   <= 16'h0000;
      r_motor    <= '0;
      frame_ob   <= '0;
      sof_o      <= 1'b0;
      snapshot_o <= 1'b0;
    end else begin
      if (w_cnt_inc) begin
        r_sf_cnt <= r_sf_cnt + 16'd1;
      end
      if (w_snap) begin
        r_motor <= motor_status_ib;
      end
      snapshot_o <= w_snap;
      if (frame_strobe_i) begin
        frame_ob <= {w_body, w_crc};
        sof_o    <= (w_next_state == ST_HEADER);
      end
    end
  end

endmodule

// File: tb/tb_mcoi_status_framer.sv
module tb_mcoi_status_framer;
  import mcoi_status_framer_pkg::*;

  logic              clk;
  logic              rst;
  ckrs_t             clkrs;
  logic              enable;
  logic              strobe;
  logic [15:0][15:0] motors;
  logic [31:0]       diag;
  logic [79:0]       frame;
  logic              sof;
  logic              snap;

  int n_checks = 0;
  int n_fail   = 0;

  assign clkrs.clk   = clk;
  assign clkrs.reset = rst;

  mcoi_status_framer #(.NUM_MOTORS(16)) dut (
    .ClkRs_ix        (clkrs),
    .enable_i        (enable),
    .frame_strobe_i  (strobe),
    .motor_status_ib (motors),
    .diag_ib         (diag),
    .frame_ob        (frame),
    .sof_o           (sof),
    .snapshot_o      (snap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wise CRC-8 reference (poly 0x07, init 0, MSB first)
  function automatic logic [7:0] ref_crc(input logic [71:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 8; b >= 0; b--) begin
      c = c ^ d[b*8 +: 8];
      for (int j = 0; j < 8; j++) begin
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  function automatic logic [79:0] mk_frame(input logic [3:0] m, input logic [3:0] idx,
                                           input logic [63:0] pl);
    logic [71:0] body;
    body = {m, idx, pl};
    return {body, ref_crc(body)};
  endfunction

  function automatic logic [79:0] mk_hdr(input logic [15:0] cnt, input logic [31:0] dg);
    return mk_frame(4'hA, 4'h0, {cnt, dg, 8'd16, 8'h00});
  endfunction

  // Motor i held base+i; frame k carries motors 4(k-1)+3 .. 4(k-1)
  function automatic logic [79:0] mk_mot(input int k, input logic [15:0] base);
    logic [15:0] m0;
    m0 = base + 16'(4 * (k - 1));
    return mk_frame(4'h5, 4'(k), {m0 + 16'd3, m0 + 16'd2, m0 + 16'd1, m0});
  endfunction

  task automatic set_motors(input logic [15:0] base);
    for (int i = 0; i < 16; i++) motors[i] = base + 16'(i);
  endtask

  // Called at a negedge; returns at the negedge after the strobed edge
  task automatic pulse;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      strobe = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (frame !== 80'h0) begin
        $display("FAIL reset_frame: got %h expected %h", frame, 80'h0); n_fail++;
      end
      n_checks++;
      if (sof !== 1'b0) begin
        $display("FAIL reset_sof: got %b expected 0", sof); n_fail++;
      end
      n_checks++;
      if (snap !== 1'b0) begin
        $display("FAIL reset_snapshot: got %b expected 0", snap); n_fail++;
      end
    end
    strobe = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_header;
    logic [79:0] exp_f;
    diag = 32'hDEADBEEF;
    set_motors(16'h1000);
    pulse();
    exp_f = mk_hdr(16'h0000, 32'hDEADBEEF);
    n_checks++;
    if (frame[79:72] !== 8'hA0) begin
      $display("FAIL hdr_marker_index: got %h expected a0", frame[79:72]); n_fail++;
    end
    n_checks++;
    if (frame[71:56] !== 16'h0000) begin
      $display("FAIL hdr_counter: got %h expected 0000", frame[71:56]); n_fail++;
    end
    n_checks++;
    if (frame[55:24] !== 32'hDEADBEEF) begin
      $display("FAIL hdr_diag: got %h expected deadbeef", frame[55:24]); n_fail++;
    end
    n_checks++;
    if (frame[23:8] !== 16'h1000) begin
      $display("FAIL hdr_nmotors: got %h expected 1000", frame[23:8]); n_fail++;
    end
    n_checks++;
    if (frame[7:0] !== ref_crc(frame[79:8])) begin
      $display("FAIL hdr_crc: got %h expected %h", frame[7:0], ref_crc(frame[79:8])); n_fail++;
    end
    n_checks++;
    if (frame !== exp_f) begin
      $display("FAIL hdr_frame: got %h expected %h", frame, exp_f); n_fail++;
    end
    n_checks++;
    if (sof !== 1'b1 || snap !== 1'b1) begin
      $display("FAIL hdr_flags: got sof=%b snap=%b expected 1 1", sof, snap); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (frame !== exp_f || sof !== 1'b1 || snap !== 1'b0) begin
      $display("FAIL hdr_hold: got %h sof=%b snap=%b expected %h 1 0", frame, sof, snap, exp_f);
      n_fail++;
    end
  endtask

  task automatic test_motor_frames;
    logic [79:0] exp_f;
    set_motors(16'h2000);
    diag = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      pulse();
      exp_f = mk_mot(k, 16'h1000);
      n_checks++;
      if (frame !== exp_f) begin
        $display("FAIL motor_frame_%0d: got %h expected %h", k, frame, exp_f); n_fail++;
      end
      n_checks++;
      if (sof !== 1'b0 || snap !== 1'b0) begin
        $display("FAIL motor_flags_%0d: got sof=%b snap=%b expected 0 0", k, sof, snap); n_fail++;
      end
      if (k == 1) begin
        n_checks++;
        if (frame[71:8] !== 64'h1003_1002_1001_1000) begin
          $display("FAIL motor1_payload: got %h expected 1003100210011000", frame[71:8]);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [79:0] exp_f;
    pulse();
    exp_f = mk_hdr(16'h0001, 32'h12345678);
    n_checks++;
    if (frame !== exp_f || snap !== 1'b1) begin
      $display("FAIL drop_hdr1: got %h snap=%b expected %h 1", frame, snap, exp_f); n_fail++;
    end
    pulse();
    pulse();
    enable = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      pulse();
      exp_f = mk_mot(k, 16'h2000);
      n_checks++;
      if (frame !== exp_f) begin
        $display("FAIL drop_motor_%0d: got %h expected %h", k, frame, exp_f); n_fail++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      pulse();
      n_checks++;
      if (frame !== 80'h0 || sof !== 1'b0 || snap !== 1'b0) begin
        $display("FAIL drop_idle_%0d: got %h sof=%b snap=%b expected 0", i, frame, sof, snap);
        n_fail++;
      end
    end
    enable = 1'b1;
    diag   = 32'hCAFEF00D;
    pulse();
    exp_f = mk_hdr(16'h0002, 32'hCAFEF00D);
    n_checks++;
    if (frame !== exp_f || sof !== 1'b1) begin
      $display("FAIL drop_reenable_hdr: got %h sof=%b expected %h 1", frame, sof, exp_f); n_fail++;
    end
  endtask

  task automatic test_reset_mid;
    logic [79:0] exp_f;
    pulse();
    pulse();
    exp_f = mk_mot(2, 16'h2000);
    n_checks++;
    if (frame !== exp_f) begin
      $display("FAIL rstmid_motor2: got %h expected %h", frame, exp_f); n_fail++;
    end
    rst    = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    strobe = 1'b0;
    n_checks++;
    if (frame !== 80'h0 || sof !== 1'b0 || snap !== 1'b0) begin
      $display("FAIL rstmid_idle: got %h sof=%b snap=%b expected 0", frame, sof, snap); n_fail++;
    end
    @(negedge clk);
    pulse();
    exp_f = mk_hdr(16'h0000, 32'hCAFEF00D);
    n_checks++;
    if (frame !== exp_f || snap !== 1'b1) begin
      $display("FAIL rstmid_hdr: got %h snap=%b expected %h 1", frame, snap, exp_f); n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    logic [79:0] exp_f;
    int          pos;
    for (int k = 1; k <= 4; k++) pulse();
    enable = 1'b0;
    pulse();
    n_checks++;
    if (frame !== 80'h0) begin
      $display("FAIL b2b_idle: got %h expected 0", frame); n_fail++;
    end
    // Jump the superframe counter close to wrap instead of running 65536 superframes
    force dut.r_sf_cnt = 16'hFFFD;
    #1;
    release dut.r_sf_cnt;
    enable = 1'b1;
    strobe = 1'b1;
    for (int f = 0; f < 20; f++) begin
      @(negedge clk);
      pos = f % 5;
      exp_f = (pos == 0) ? mk_hdr(16'hFFFD + 16'(f / 5), 32'hCAFEF00D) : mk_mot(pos, 16'h2000);
      n_checks++;
      if (frame !== exp_f) begin
        $display("FAIL b2b_frame_%0d: got %h expected %h", f, frame, exp_f); n_fail++;
      end
      n_checks++;
      if (snap !== (pos == 0) || sof !== (pos == 0)) begin
        $display("FAIL b2b_flags_%0d: got sof=%b snap=%b expected %b", f, sof, snap, pos == 0);
        n_fail++;
      end
    end
    strobe = 1'b0;
    @(negedge clk);
    exp_f = mk_mot(4, 16'h2000);
    n_checks++;
    if (frame !== exp_f) begin
      $display("FAIL b2b_hold: got %h expected %h", frame, exp_f); n_fail++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    strobe = 1'b0;
    diag   = 32'h0;
    set_motors(16'h0000);
    test_reset();
    test_first_header();
    test_motor_frames();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
